// File: rtl/gp_regfile_param.sv
// rtl/gp_regfile_param.sv - parametrised GP register file with half-word aliasing, forwarding and busy scoreboard
//
// Purpose:
//   NREGS x WIDTH general-purpose register file. Every register can be
//   accessed as a full word, as its low half or as its high half. The halves
//   alias the same storage. There are two independent registered read ports
//   and one write port. A same-cycle write to the register being read is
//   forwarded into the read result. A per-register busy scoreboard tracks
//   pending writebacks for the control unit.
//
// Parameters:
//   WIDTH  register width in bits (even, >= 4); HW = WIDTH/2
//   NREGS  number of registers (>= 2)
//   AW     address width, derived from NREGS
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_en, wr_addr, wr_mode,    write port; mode 00 full, 01 low half,
//   wr_data                     10 high half, 11 ignored
//   rd_en_x, rd_addr_x,         read port request (x = a, b); mode 11 reads
//   rd_mode_x                   as a full word
//   rd_data_x, rd_valid_x,      registered read result, valid strobe,
//   rd_busy_x, rd_err_x         scoreboard bit and out-of-range flag
//   busy_set, busy_addr         mark a register as having a pending write
//   busy_vec                    current scoreboard
//
// All outputs are registered; there is no combinational input-to-output path.

module gp_regfile_param #(
   parameter int WIDTH = 20,
   parameter int NREGS = 6,
   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [1:0]       wr_mode,
   input  logic [WIDTH-1:0] wr_data,

   input  logic             rd_en_a,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [1:0]       rd_mode_a,
   output logic [WIDTH-1:0] rd_data_a,
   output logic             rd_valid_a,
   output logic             rd_busy_a,
   output logic             rd_err_a,

   input  logic             rd_en_b,
   input  logic [AW-1:0]    rd_addr_b,
   input  logic [1:0]       rd_mode_b,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid_b,
   output logic             rd_busy_b,
   output logic             rd_err_b,

   input  logic             busy_set,
   input  logic [AW-1:0]    busy_addr,
   output logic [NREGS-1:0] busy_vec
);

   localparam int HW = WIDTH / 2;

   // NREGS in an address-sized-plus-one vector so range checks never truncate
   localparam logic [AW:0] NREGS_L = (AW + 1)'(NREGS);

   localparam logic [1:0] MODE_FULL = 2'b00;
   localparam logic [1:0] MODE_LOW  = 2'b01;
   localparam logic [1:0] MODE_HIGH = 2'b10;

   // Storage
   logic [WIDTH-1:0] regs [NREGS];

   // Apply a write of the given mode on top of the old register contents.
   // Both half modes take their payload from the low half of the write data.
   function automatic logic [WIDTH-1:0] merge_write(
      input logic [WIDTH-1:0] old_val,
      input logic [1:0]       mode,
      input logic [WIDTH-1:0] data
   );
      logic [WIDTH-1:0] res;
      res = old_val;
      case (mode)
         MODE_FULL: res = data;
         MODE_LOW:  res = {old_val[WIDTH-1:HW], data[HW-1:0]};
         MODE_HIGH: res = {data[HW-1:0], old_val[HW-1:0]};
         default:   res = old_val;
      endcase
      return res;
   endfunction

   // Select the requested view of a register; half views are zero-extended
   // into the low half of the result. Mode 11 falls through to a full read.
   function automatic logic [WIDTH-1:0] select_view(
      input logic [WIDTH-1:0] val,
      input logic [1:0]       mode
   );
      logic [WIDTH-1:0] res;
      case (mode)
         MODE_LOW:  res = {{HW{1'b0}}, val[HW-1:0]};
         MODE_HIGH: res = {{HW{1'b0}}, val[WIDTH-1:HW]};
         default:   res = val;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------
   logic             wr_in_range;
   logic             wr_valid;
   logic [WIDTH-1:0] wr_merged;

   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < NREGS_L);
      wr_valid    = wr_en && wr_in_range && (wr_mode != 2'b11);
      wr_merged   = '0;
      if (wr_in_range) begin
         wr_merged = merge_write(regs[wr_addr], wr_mode, wr_data);
      end
   end

   // ------------------------------------------------------------------
   // Read ports: next-state values for the registered outputs
   // ------------------------------------------------------------------
   logic             a_in_range, a_fwd;
   logic [WIDTH-1:0] a_src, a_data_n;
   logic             a_busy_n;

   logic             b_in_range, b_fwd;
   logic [WIDTH-1:0] b_src, b_data_n;
   logic             b_busy_n;

   always_comb begin
      a_in_range = ({1'b0, rd_addr_a} < NREGS_L);
      // Forward the merged value so the read sees this cycle's write
      a_fwd      = wr_valid && (wr_addr == rd_addr_a);
      a_src      = '0;
      a_data_n   = '0;
      a_busy_n   = 1'b0;
      if (a_in_range) begin
         a_src    = a_fwd ? wr_merged : regs[rd_addr_a];
         a_data_n = select_view(a_src, rd_mode_a);
         // A forwarded write is the writeback itself, so it is no longer pending
         a_busy_n = busy_vec[rd_addr_a] && !a_fwd;
      end
   end

   always_comb begin
      b_in_range = ({1'b0, rd_addr_b} < NREGS_L);
      b_fwd      = wr_valid && (wr_addr == rd_addr_b);
      b_src      = '0;
      b_data_n   = '0;
      b_busy_n   = 1'b0;
      if (b_in_range) begin
         b_src    = b_fwd ? wr_merged : regs[rd_addr_b];
         b_data_n = select_view(b_src, rd_mode_b);
         b_busy_n = busy_vec[rd_addr_b] && !b_fwd;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard next state: write clears first, set applied last so a
   // same-cycle set wins over the clear.
   // ------------------------------------------------------------------
   logic             busy_in_range;
   logic [NREGS-1:0] busy_next;

   always_comb begin
      busy_in_range = ({1'b0, busy_addr} < NREGS_L);
      busy_next     = busy_vec;
      if (wr_valid) begin
         busy_next[wr_addr] = 1'b0;
      end
      if (busy_set && busy_in_range) begin
         busy_next[busy_addr] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         busy_vec   <= '0;
         rd_data_a  <= '0;
         rd_valid_a <= 1'b0;
         rd_busy_a  <= 1'b0;
         rd_err_a   <= 1'b0;
         rd_data_b  <= '0;
         rd_valid_b <= 1'b0;
         rd_busy_b  <= 1'b0;
         rd_err_b   <= 1'b0;
      end else begin
         if (wr_valid) begin
            regs[wr_addr] <= wr_merged;
         end
         busy_vec <= busy_next;

         // Result fields hold their last value while the port is idle
         rd_valid_a <= rd_en_a;
         if (rd_en_a) begin
            rd_data_a <= a_data_n;
            rd_busy_a <= a_busy_n;
            rd_err_a  <= !a_in_range;
         end

         rd_valid_b <= rd_en_b;
         if (rd_en_b) begin
            rd_data_b <= b_data_n;
            rd_busy_b <= b_busy_n;
            rd_err_b  <= !b_in_range;
         end
      end
   end

endmodule

// File: tb/tb_gp_regfile_param.sv
// tb/tb_gp_regfile_param.sv - directed bench for gp_regfile_param at three parameter points
//
// Purpose:
//   Drives one shared stimulus bus into three instances: the default
//   configuration (WIDTH 20, NREGS 6), a wide one (WIDTH 32, NREGS 16) and a
//   minimal one (WIDTH 8, NREGS 2). Each instance takes the low bits of the
//   shared address and data buses. Expected values are hand-computed.

module tb_gp_regfile_param;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [1:0]  wr_mode;
   logic [31:0] wr_data;
   logic        rd_en_a, rd_en_b;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [1:0]  rd_mode_a, rd_mode_b;
   logic        busy_set;
   logic [3:0]  busy_addr;

   // default instance (20 x 6)
   logic [19:0] d_rd_data_a, d_rd_data_b;
   logic        d_rd_valid_a, d_rd_valid_b, d_rd_busy_a, d_rd_busy_b, d_rd_err_a, d_rd_err_b;
   logic [5:0]  d_busy_vec;
   // wide instance (32 x 16)
   logic [31:0] w_rd_data_a, w_rd_data_b;
   logic        w_rd_valid_a, w_rd_valid_b, w_rd_busy_a, w_rd_busy_b, w_rd_err_a, w_rd_err_b;
   logic [15:0] w_busy_vec;
   // narrow instance (8 x 2)
   logic [7:0]  n_rd_data_a, n_rd_data_b;
   logic        n_rd_valid_a, n_rd_valid_b, n_rd_busy_a, n_rd_busy_b, n_rd_err_a, n_rd_err_b;
   logic [1:0]  n_busy_vec;

   int vectors;
   int miscompares;

   gp_regfile_param #(.WIDTH(20), .NREGS(6)) u_dut_d (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_mode(wr_mode), .wr_data(wr_data[19:0]),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a[2:0]), .rd_mode_a(rd_mode_a),
      .rd_data_a(d_rd_data_a), .rd_valid_a(d_rd_valid_a), .rd_busy_a(d_rd_busy_a), .rd_err_a(d_rd_err_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b[2:0]), .rd_mode_b(rd_mode_b),
      .rd_data_b(d_rd_data_b), .rd_valid_b(d_rd_valid_b), .rd_busy_b(d_rd_busy_b), .rd_err_b(d_rd_err_b),
      .busy_set(busy_set), .busy_addr(busy_addr[2:0]), .busy_vec(d_busy_vec)
   );

   gp_regfile_param #(.WIDTH(32), .NREGS(16)) u_dut_w (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_mode(wr_mode), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_mode_a(rd_mode_a),
      .rd_data_a(w_rd_data_a), .rd_valid_a(w_rd_valid_a), .rd_busy_a(w_rd_busy_a), .rd_err_a(w_rd_err_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_mode_b(rd_mode_b),
      .rd_data_b(w_rd_data_b), .rd_valid_b(w_rd_valid_b), .rd_busy_b(w_rd_busy_b), .rd_err_b(w_rd_err_b),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(w_busy_vec)
   );

   gp_regfile_param #(.WIDTH(8), .NREGS(2)) u_dut_n (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr[0:0]), .wr_mode(wr_mode), .wr_data(wr_data[7:0]),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a[0:0]), .rd_mode_a(rd_mode_a),
      .rd_data_a(n_rd_data_a), .rd_valid_a(n_rd_valid_a), .rd_busy_a(n_rd_busy_a), .rd_err_a(n_rd_err_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b[0:0]), .rd_mode_b(rd_mode_b),
      .rd_data_b(n_rd_data_b), .rd_valid_b(n_rd_valid_b), .rd_busy_b(n_rd_busy_b), .rd_err_b(n_rd_err_b),
      .busy_set(busy_set), .busy_addr(busy_addr[0:0]), .busy_vec(n_busy_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_data = '0;
      rd_en_a = 1'b0; rd_addr_a = '0; rd_mode_a = '0;
      rd_en_b = 1'b0; rd_addr_b = '0; rd_mode_b = '0;
      busy_set = 1'b0; busy_addr = '0;

      // ---- reset state ----
      tick();
      chk("rst_data_a",  32'(d_rd_data_a),  32'h0);
      chk("rst_valid_a", 32'(d_rd_valid_a), 32'h0);
      chk("rst_err_b",   32'(d_rd_err_b),   32'h0);
      chk("rst_busyvec", 32'(d_busy_vec),   32'h0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_en_a = 1'b1; rd_addr_a = i[3:0]; rd_mode_a = 2'b00;
         tick();
         chk("rst_reg_zero", 32'(d_rd_data_a), 32'h0);
      end

      // ---- 1: full write then read ----
      rd_en_a = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd3; wr_mode = 2'b00; wr_data = 32'h000ABCDE;
      tick();
      chk("s1_idle_valid", 32'(d_rd_valid_a), 32'h0);
      wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_mode_a = 2'b00;
      tick();
      chk("s1_data",  32'(d_rd_data_a),  32'h000ABCDE);
      chk("s1_valid", 32'(d_rd_valid_a), 32'h1);
      rd_en_a = 1'b0;
      tick();
      chk("s1_valid_drop", 32'(d_rd_valid_a), 32'h0);
      chk("s1_data_hold",  32'(d_rd_data_a),  32'h000ABCDE);

      // ---- 2: half aliasing ----
      wr_en = 1'b1; wr_addr = 4'd1; wr_mode = 2'b00; wr_data = 32'h00012345;
      tick();
      wr_mode = 2'b01; wr_data = 32'h000003FF;
      tick();
      wr_mode = 2'b10; wr_data = 32'h00000001;
      tick();
      wr_en = 1'b0;
      rd_en_a = 1'b1; rd_addr_a = 4'd1; rd_mode_a = 2'b00;
      rd_en_b = 1'b1; rd_addr_b = 4'd1; rd_mode_b = 2'b01;
      tick();
      chk("s2_full", 32'(d_rd_data_a), 32'h000007FF);
      chk("s2_low",  32'(d_rd_data_b), 32'h000003FF);
      rd_mode_a = 2'b10; rd_en_b = 1'b0;
      tick();
      chk("s2_high",     32'(d_rd_data_a),  32'h00000001);
      chk("s2_b_hold",   32'(d_rd_data_b),  32'h000003FF);
      chk("s2_b_nvalid", 32'(d_rd_valid_b), 32'h0);

      // ---- 3: forwarding on both ports, busy masked ----
      rd_en_a = 1'b0;
      busy_set = 1'b1; busy_addr = 4'd2;
      tick();
      busy_set = 1'b0;
      chk("s3_busy_set", 32'(d_busy_vec), 32'h04);
      wr_en = 1'b1; wr_addr = 4'd2; wr_mode = 2'b00; wr_data = 32'h00055555;
      rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_mode_a = 2'b00;
      rd_en_b = 1'b1; rd_addr_b = 4'd2; rd_mode_b = 2'b10;
      tick();
      chk("s3_fwd_a",  32'(d_rd_data_a),  32'h00055555);
      chk("s3_fwd_b",  32'(d_rd_data_b),  32'h00000155);
      chk("s3_busy_a", 32'(d_rd_busy_a),  32'h0);
      chk("s3_busy_b", 32'(d_rd_busy_b),  32'h0);
      chk("s3_valid_b", 32'(d_rd_valid_b), 32'h1);
      chk("s3_busy_clr", 32'(d_busy_vec), 32'h00);
      wr_addr = 4'd3; wr_mode = 2'b01; wr_data = 32'h00000001;
      rd_addr_a = 4'd3; rd_mode_a = 2'b00; rd_en_b = 1'b0;
      tick();
      chk("s3_fwd_half", 32'(d_rd_data_a), 32'h000ABC01);

      // ---- 4: scoreboard ----
      wr_en = 1'b0; rd_en_a = 1'b0;
      busy_set = 1'b1; busy_addr = 4'd4;
      tick();
      busy_set = 1'b0;
      chk("s4_busy_vec", 32'(d_busy_vec), 32'h10);
      rd_en_a = 1'b1; rd_addr_a = 4'd4; rd_mode_a = 2'b00;
      tick();
      chk("s4_rd_busy", 32'(d_rd_busy_a), 32'h1);
      rd_en_a = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd4; wr_mode = 2'b00; wr_data = 32'h00000011;
      busy_set = 1'b1; busy_addr = 4'd4;
      tick();
      chk("s4_set_wins", 32'(d_busy_vec), 32'h10);
      busy_set = 1'b0; wr_data = 32'h00000022;
      tick();
      chk("s4_wr_clears", 32'(d_busy_vec), 32'h00);
      wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd4;
      tick();
      chk("s4_data",    32'(d_rd_data_a), 32'h00000022);
      chk("s4_nbusy",   32'(d_rd_busy_a), 32'h0);

      // ---- 5: out of range and reserved mode ----
      rd_addr_a = 4'd7;
      rd_en_b = 1'b1; rd_addr_b = 4'd6; rd_mode_b = 2'b00;
      wr_en = 1'b1; wr_addr = 4'd6; wr_mode = 2'b00; wr_data = 32'h000FFFFF;
      tick();
      chk("s5_err_a",  32'(d_rd_err_a),   32'h1);
      chk("s5_data_a", 32'(d_rd_data_a),  32'h0);
      chk("s5_busy_a", 32'(d_rd_busy_a),  32'h0);
      chk("s5_err_b",  32'(d_rd_err_b),   32'h1);
      chk("s5_valid",  32'(d_rd_valid_a), 32'h1);
      wr_addr = 4'd1; wr_mode = 2'b11;
      rd_addr_a = 4'd1; rd_mode_a = 2'b00; rd_en_b = 1'b0;
      tick();
      chk("s5_rsv_nofwd", 32'(d_rd_data_a), 32'h000007FF);
      chk("s5_err_clr",   32'(d_rd_err_a),  32'h0);
      wr_en = 1'b0;
      busy_set = 1'b1; busy_addr = 4'd7;
      rd_addr_a = 4'd3;
      tick();
      busy_set = 1'b0;
      chk("s5_busy_oor", 32'(d_busy_vec),  32'h00);
      chk("s5_reg3",     32'(d_rd_data_a), 32'h000ABC01);
      rd_addr_a = 4'd0; rd_en_b = 1'b1; rd_addr_b = 4'd1;
      tick();
      chk("s5_reg0", 32'(d_rd_data_a), 32'h0);
      chk("s5_reg1", 32'(d_rd_data_b), 32'h000007FF);

      // ---- reset mid-stream ----
      reset = 1'b1;
      rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_en_b = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd2; wr_mode = 2'b00; wr_data = 32'h00012345;
      busy_set = 1'b1; busy_addr = 4'd5;
      tick();
      chk("rm_valid", 32'(d_rd_valid_a), 32'h0);
      chk("rm_data",  32'(d_rd_data_a),  32'h0);
      chk("rm_busy",  32'(d_busy_vec),   32'h0);
      reset = 1'b0; wr_en = 1'b0; busy_set = 1'b0;
      tick();
      chk("rm_nocommit", 32'(d_rd_data_a), 32'h0);

      // ---- 6: sweep, wide (32x16) and narrow (8x2) ----
      rd_en_a = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd3; wr_mode = 2'b00; wr_data = 32'hDEADBEEF;
      tick();
      wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_mode_a = 2'b00;
      tick();
      chk("w1_data",  w_rd_data_a,          32'hDEADBEEF);
      chk("w1_valid", 32'(w_rd_valid_a),    32'h1);
      chk("n1_data",  32'(n_rd_data_a),     32'h000000EF);

      rd_en_a = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd1; wr_mode = 2'b00; wr_data = 32'h12345678;
      tick();
      wr_mode = 2'b01; wr_data = 32'h0000ABCD;
      tick();
      wr_mode = 2'b10; wr_data = 32'h00000009;
      tick();
      wr_en = 1'b0;
      rd_en_a = 1'b1; rd_addr_a = 4'd1; rd_mode_a = 2'b00;
      rd_en_b = 1'b1; rd_addr_b = 4'd1; rd_mode_b = 2'b01;
      tick();
      chk("w2_full", w_rd_data_a,       32'h0009ABCD);
      chk("w2_low",  w_rd_data_b,       32'h0000ABCD);
      chk("n2_full", 32'(n_rd_data_a),  32'h0000009D);
      chk("n2_low",  32'(n_rd_data_b),  32'h0000000D);
      rd_mode_a = 2'b10; rd_en_b = 1'b0;
      tick();
      chk("w2_high", w_rd_data_a,       32'h00000009);
      chk("n2_high", 32'(n_rd_data_a),  32'h00000009);

      rd_en_a = 1'b0;
      busy_set = 1'b1; busy_addr = 4'd2;
      tick();
      busy_set = 1'b0;
      chk("w3_busy_set", 32'(w_busy_vec), 32'h0004);
      chk("n3_busy_set", 32'(n_busy_vec), 32'h1);
      wr_en = 1'b1; wr_addr = 4'd2; wr_mode = 2'b00; wr_data = 32'hA5A5F03C;
      rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_mode_a = 2'b00;
      rd_en_b = 1'b1; rd_addr_b = 4'd2; rd_mode_b = 2'b10;
      tick();
      chk("w3_fwd_a",   w_rd_data_a,       32'hA5A5F03C);
      chk("w3_fwd_b",   w_rd_data_b,       32'h0000A5A5);
      chk("n3_fwd_a",   32'(n_rd_data_a),  32'h0000003C);
      chk("n3_fwd_b",   32'(n_rd_data_b),  32'h00000003);
      chk("w3_busy_a",  32'(w_rd_busy_a),  32'h0);
      chk("n3_busy_b",  32'(n_rd_busy_b),  32'h0);
      chk("w3_busy_clr", 32'(w_busy_vec),  32'h0);
      chk("n3_busy_clr", 32'(n_busy_vec),  32'h0);

      rd_en_a = 1'b0; rd_en_b = 1'b0;
      wr_addr = 4'd15; wr_data = 32'h13579BDF;
      tick();
      wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd15; rd_mode_a = 2'b00;
      tick();
      chk("w_maxaddr",   w_rd_data_a,      32'h13579BDF);
      chk("w_maxaddr_e", 32'(w_rd_err_a),  32'h0);
      chk("n_maxaddr",   32'(n_rd_data_a), 32'h000000DF);
      chk("d_addr7_err", 32'(d_rd_err_a),  32'h1);

      reset = 1'b1;
      rd_en_a = 1'b1; rd_en_b = 1'b1;
      tick();
      chk("rm_d_valid_a", 32'(d_rd_valid_a), 32'h0);
      chk("rm_w_valid_a", 32'(w_rd_valid_a), 32'h0);
      chk("rm_n_valid_b", 32'(n_rd_valid_b), 32'h0);
      chk("rm_w_data_a",  w_rd_data_a,       32'h0);
      reset = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
